sensor_monitor: RTL and testbench
=================================

// Module: sensor_monitor
// PURPOSE
//  Sits directly downstream of the delay-line sensor. Samples delayed_clk on
//  each rising clk edge and flags a timing event when the sample differs from
//  EXPECTED, i.e. the delay chain slowed or was glitched. Counts events over
//  fixed windows and raises a sticky alarm when a window count reaches
//  threshold. Provides the digital readout for the microtile.
// PARAMETERS
//  WINDOW_W  8     window length = 2**WINDOW_W monitored cycles
//  CNT_W     8     width of event counter / threshold / event_count
//  WARMUP    4     cycles ignored after enable or clear (sync flush), >=2
//  EXPECTED  1'b0  delayed_clk value sampled by clk under nominal conditions
// PORTS
//  clk          in   1      system clock (sensor input is its inversion)
//  rst          in   1      async reset, active-high
//  delayed_clk  in   1      delayed clock from sensor (async to sampling path)
//  en           in   1      monitor enable, level
//  clear        in   1      1-cycle pulse: drop alarm, restart window
//  threshold    in   CNT_W  alarm level; 0 = alarm disabled
//  alarm        out  1      sticky alarm
//  event_count  out  CNT_W  event count of last closed window
//  window_done  out  1      1-cycle pulse when a window closes
//  state        out  2      FSM state: 0 IDLE, 1 WARMUP, 2 MONITOR, 3 ALARM
// BEHAVIOUR
//  - Reset (async, any time): all outputs, counters, sync flops = 0; IDLE.
//  - Sampling: s1 <= delayed_clk; s2 <= s1. mismatch = (s2 != EXPECTED).
//    2-cycle latency from delayed_clk to mismatch. Sync runs in all states.
//  - IDLE: counters held at 0. en=1 -> WARMUP.
//  - WARMUP: wcnt counts 0..WARMUP-1, mismatches ignored; on last -> MONITOR.
//  - MONITOR: win_cnt increments every cycle. ev_cnt += mismatch, saturates
//    at 2**CNT_W-1, no wrap. On edge where win_cnt == 2**WINDOW_W-1:
//    event_count <= ev_cnt + that cycle's mismatch (saturated);
//    window_done <= 1 for one cycle; win_cnt, ev_cnt <= 0.
//    If threshold != 0 and closed count >= threshold -> ALARM and alarm <= 1
//    on the same edge. Else remain MONITOR, next window starts immediately.
//  - ALARM: alarm=1 and held; counting stops; event_count frozen.
//    Leaves only via clear or en=0.
//  - clear (MONITOR or ALARM, en=1): alarm <= 0, event_count <= 0, counters
//    <= 0, -> WARMUP. clear in IDLE/WARMUP: no effect beyond zeroing
//    event_count.
//  - en=0 in any state -> IDLE next edge; counters zeroed; alarm and
//    event_count hold their values (alarm still needs clear to drop).
//  - Priority per edge: en=0 > clear > window close > count.
//  - window_done and clear same edge: clear wins, no pulse, no alarm.
//  - threshold sampled only at window close; may change at any time.
// TESTING
//  1. en=1, delayed_clk=EXPECTED, threshold=1 -> state 1 for 4 cycles, then 2;
//     window_done every 256 cycles; event_count=0; alarm=0.
//  2. 5 mismatch cycles in one window, threshold=5 -> at close event_count=5,
//     alarm=1, state=3 on same edge; held over 1000 further cycles.
//  3. Same stimulus, threshold=6 -> event_count=5, alarm=0, state stays 2;
//     next clean window closes with event_count=0.
//  4. delayed_clk=~EXPECTED constantly, threshold=0 -> event_count=255
//     (saturated), alarm never set.
//  5. ALARM, pulse clear with en=1 -> alarm=0, event_count=0, state 1 for
//     4 cycles then 2; also clear coincident with window close -> no pulse.
//  6. Assert rst mid-window (async, between edges) -> all outputs 0
//     immediately; en drop mid-window -> state 0 next edge, alarm held.

Source files
------------

// File: rtl/sensor_monitor_if.sv
// rtl/sensor_monitor_if.sv - sensor monitor signal bundle
// Sensor input, control and readout signals grouped for the monitor and its driver.
interface sensor_monitor_if #(
  parameter int CNT_W = 8
);
  logic             delayed_clk;
  logic             en;
  logic             clear;
  logic [CNT_W-1:0] threshold;
  logic             alarm;
  logic [CNT_W-1:0] event_count;
  logic             window_done;
  logic [1:0]       state;

  modport master (
    output delayed_clk, en, clear, threshold,
    input  alarm, event_count, window_done, state
  );

  modport slave (
    input  delayed_clk, en, clear, threshold,
    output alarm, event_count, window_done, state
  );
endinterface

// File: rtl/sensor_monitor.sv
// rtl/sensor_monitor.sv - delay-line timing event monitor
// Samples the sensor's delayed clock, counts mismatches per window, raises a sticky alarm.
module sensor_monitor #(
  parameter int   WINDOW_W = 8,
  parameter int   CNT_W    = 8,
  parameter int   WARMUP   = 4,
  parameter logic EXPECTED = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sensor_monitor_if.slave bus
);
  localparam int WC_W = $clog2(WARMUP);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WARMUP - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_MONITOR = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                s1_q, s1_d, s2_q, s2_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [WINDOW_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]    ev_cnt_q, ev_cnt_d;
  logic [CNT_W-1:0]    event_count_q, event_count_d;
  logic                alarm_q, alarm_d;
  logic                window_done_q, window_done_d;
  logic                mismatch;
  logic [CNT_W-1:0]    ev_sum;

  always_comb begin
    s1_d          = bus.delayed_clk;
    s2_d          = s1_q;
    mismatch      = (s2_q != EXPECTED);
    ev_sum        = (mismatch && (ev_cnt_q != '1)) ? ev_cnt_q + CNT_W'(1) : ev_cnt_q;
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    win_cnt_d     = win_cnt_q;
    ev_cnt_d      = ev_cnt_q;
    event_count_d = event_count_q;
    alarm_d       = alarm_q;
    window_done_d = 1'b0;

    if (!bus.en) begin
      // Disable keeps alarm and last readout; only counters are flushed.
      state_d   = ST_IDLE;
      wcnt_d    = '0;
      win_cnt_d = '0;
      ev_cnt_d  = '0;
      if (state_q == ST_IDLE && bus.clear) event_count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WARMUP;
          wcnt_d  = '0;
          if (bus.clear) event_count_d = '0;
        end
        ST_WARMUP: begin
          if (bus.clear) event_count_d = '0;
          if (wcnt_q == WC_LAST) begin
            state_d = ST_MONITOR;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
        ST_MONITOR, ST_ALARM: begin
          if (bus.clear) begin
            state_d       = ST_WARMUP;
            alarm_d       = 1'b0;
            event_count_d = '0;
            wcnt_d        = '0;
            win_cnt_d     = '0;
            ev_cnt_d      = '0;
          end else if (state_q == ST_MONITOR) begin
            if (win_cnt_q == '1) begin
              event_count_d = ev_sum;
              window_done_d = 1'b1;
              win_cnt_d     = '0;
              ev_cnt_d      = '0;
              if ((bus.threshold != '0) && (ev_sum >= bus.threshold)) begin
                state_d = ST_ALARM;
                alarm_d = 1'b1;
              end
            end else begin
              win_cnt_d = win_cnt_q + WINDOW_W'(1);
              ev_cnt_d  = ev_sum;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      wcnt_q        <= '0;
      win_cnt_q     <= '0;
      ev_cnt_q      <= '0;
      event_count_q <= '0;
      alarm_q       <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      wcnt_q        <= wcnt_d;
      win_cnt_q     <= win_cnt_d;
      ev_cnt_q      <= ev_cnt_d;
      event_count_q <= event_count_d;
      alarm_q       <= alarm_d;
      window_done_q <= window_done_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.alarm       = alarm_q;
  assign bus.event_count = event_count_q;
  assign bus.window_done = window_done_q;
endmodule

// File: tb/tb_sensor_monitor.sv
// tb/tb_sensor_monitor.sv - self-checking bench for sensor_monitor
// Directed scenarios plus a random phase, compared every cycle against a behavioural model.
module tb_sensor_monitor;
  localparam int   WINDOW_W = 8;
  localparam int   CNT_W    = 8;
  localparam int   WARMUP   = 4;
  localparam logic EXPECTED = 1'b0;
  localparam int   WIN      = 1 << WINDOW_W;
  localparam int   CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sensor_monitor_if #(.CNT_W(CNT_W)) bus();

  sensor_monitor #(
    .WINDOW_W(WINDOW_W),
    .CNT_W(CNT_W),
    .WARMUP(WARMUP),
    .EXPECTED(EXPECTED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode number, cycles spent warming, cycles into window, events so far.
  int m_state, m_warm, m_pos, m_ev, m_count;
  bit m_alarm, m_done;
  bit smp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_warm = 0; m_pos = 0; m_ev = 0; m_count = 0;
    m_alarm = 0; m_done = 0;
    smp.delete();
    smp.push_back(1'b0);
    smp.push_back(1'b0);
  endtask

  task automatic model_edge(input bit dc, input bit en, input bit clr, input int thr);
    bit mism;
    int tot;
    mism = (smp[0] != EXPECTED);
    void'(smp.pop_front());
    smp.push_back(dc);
    m_done = 0;
    if (!en) begin
      if (m_state == 0 && clr) m_count = 0;
      m_state = 0; m_warm = 0; m_pos = 0; m_ev = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_warm = 0;
      if (clr) m_count = 0;
    end else if (m_state == 1) begin
      if (clr) m_count = 0;
      m_warm++;
      if (m_warm == WARMUP) begin m_state = 2; m_warm = 0; end
    end else if (clr) begin
      m_state = 1; m_warm = 0; m_pos = 0; m_ev = 0; m_alarm = 0; m_count = 0;
    end else if (m_state == 2) begin
      tot = m_ev + int'(mism);
      if (tot > CMAX) tot = CMAX;
      if (m_pos == WIN - 1) begin
        m_count = tot; m_done = 1; m_pos = 0; m_ev = 0;
        if (thr != 0 && tot >= thr) begin m_state = 3; m_alarm = 1; end
      end else begin
        m_pos++; m_ev = tot;
      end
    end
  endtask

  task automatic check_outputs();
    chk("state", bus.state, m_state);
    chk("alarm", bus.alarm, m_alarm);
    chk("event_count", bus.event_count, m_count);
    chk("window_done", bus.window_done, m_done);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bus.delayed_clk, bus.en, bus.clear, int'(bus.threshold));
    #1;
    check_outputs();
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.window_done !== 1'b1 && n < budget);
    chk("window_done_timeout", bus.window_done, 1);
  endtask

  // Five mismatch samples placed inside one window that starts at the next edge.
  task automatic inject_window(input int count);
    int pos[5];
    for (int k = 0; k < 5; k++) pos[k] = 10 + k * 40 + int'($urandom_range(0, 30));
    for (int i = 0; i < WIN; i++) begin
      bus.delayed_clk = 1'b0;
      for (int k = 0; k < count; k++) if (pos[k] == i) bus.delayed_clk = 1'b1;
      tick();
    end
    bus.delayed_clk = 1'b0;
  endtask

  initial begin
    int n;
    int dens;
    bus.delayed_clk = 1'b0;
    bus.en          = 1'b0;
    bus.clear       = 1'b0;
    bus.threshold   = '0;
    model_reset();

    #1 rst = 1'b1;
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_event_count", bus.event_count, 0);
    chk("rst_window_done", bus.window_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean run: warmup then periodic empty windows.
    bus.threshold = 8'd1;
    bus.en        = 1'b1;
    for (int i = 0; i < WARMUP; i++) begin
      tick();
      chk("t1_warmup_state", bus.state, 1);
    end
    tick();
    chk("t1_monitor_state", bus.state, 2);
    wait_done(300, n);
    chk("t1_first_window_len", n, WIN);
    chk("t1_count", bus.event_count, 0);
    wait_done(300, n);
    chk("t1_second_window_len", n, WIN);
    chk("t1_alarm", bus.alarm, 0);

    // Five events at threshold five: alarm on the closing edge, then held.
    bus.threshold = 8'd5;
    inject_window(5);
    chk("t2_done", bus.window_done, 1);
    chk("t2_count", bus.event_count, 5);
    chk("t2_alarm", bus.alarm, 1);
    chk("t2_state", bus.state, 3);
    for (int i = 0; i < 1000; i++) begin
      bus.delayed_clk = 1'($urandom_range(0, 1));
      tick();
    end
    bus.delayed_clk = 1'b0;
    chk("t2_alarm_held", bus.alarm, 1);
    chk("t2_count_frozen", bus.event_count, 5);

    // Clear out of alarm restarts warmup.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t5_clear_alarm", bus.alarm, 0);
    chk("t5_clear_count", bus.event_count, 0);
    chk("t5_clear_state", bus.state, 1);
    for (int i = 0; i < WARMUP - 1; i++) begin
      tick();
      chk("t5_warmup_state", bus.state, 1);
    end
    tick();
    chk("t5_monitor_state", bus.state, 2);

    // Five events below threshold six: no alarm, next clean window reads zero.
    bus.threshold = 8'd6;
    wait_done(300, n);
    inject_window(5);
    chk("t3_count", bus.event_count, 5);
    chk("t3_alarm", bus.alarm, 0);
    chk("t3_state", bus.state, 2);
    wait_done(300, n);
    chk("t3_clean_len", n, WIN);
    chk("t3_clean_count", bus.event_count, 0);

    // Constant mismatch with alarm disabled saturates the count.
    bus.threshold   = 8'd0;
    bus.delayed_clk = 1'b1;
    wait_done(300, n);
    wait_done(300, n);
    chk("t4_saturated", bus.event_count, CMAX);
    chk("t4_no_alarm", bus.alarm, 0);

    // Clear on the closing edge suppresses the pulse and the alarm.
    bus.threshold = 8'd1;
    n = 0;
    while (!(m_state == 2 && m_pos == WIN - 1) && n < 600) begin
      tick();
      n++;
    end
    chk("t5_align_timeout", (n < 600), 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t5_coincident_done", bus.window_done, 0);
    chk("t5_coincident_alarm", bus.alarm, 0);
    chk("t5_coincident_state", bus.state, 1);

    // Enable drop keeps the alarm; async reset mid-window clears everything.
    wait_done(300, n);
    chk("t6_alarm_set", bus.alarm, 1);
    for (int i = 0; i < 50; i++) tick();
    bus.en = 1'b0;
    tick();
    chk("t6_en_drop_state", bus.state, 0);
    chk("t6_en_drop_alarm", bus.alarm, 1);
    bus.en = 1'b1;
    for (int i = 0; i < WARMUP + 60; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_state", bus.state, 0);
    chk("t6_rst_alarm", bus.alarm, 0);
    chk("t6_rst_event_count", bus.event_count, 0);
    chk("t6_rst_window_done", bus.window_done, 0);
    model_reset();
    #2 rst = 1'b0;

    // Random phase: varying density, threshold, clears and enable drops.
    dens = 50;
    for (int i = 0; i < 6000; i++) begin
      bus.delayed_clk = (int'($urandom_range(0, 99)) < dens);
      bus.clear       = ($urandom_range(0, 399) == 0);
      if (!bus.en && $urandom_range(0, 19) == 0) bus.en = 1'b1;
      else if ($urandom_range(0, 699) == 0) bus.en = 1'b0;
      if (bus.window_done === 1'b1 || $urandom_range(0, 999) == 0) begin
        dens          = int'($urandom_range(0, 100));
        bus.threshold = 8'($urandom_range(0, 200));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
